// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16 -- 16x-oversampling UART receiver
//
// Purpose:
//   Receives asynchronous serial frames on i_rx and emits one byte per good
//   frame. The raw pin passes through a two-flop synchroniser. A fractional
//   phase accumulator produces a 16x-baud tick, so the bit period stays
//   accurate at non-integer CLK_FREQ/BAUD ratios such as 12 MHz / 115200.
//   Each bit is sampled at tick indices 7, 8 and 9 and resolved by a 2-of-3
//   majority vote at tick 9.
//
// Optional feature macro:
//   UART_RX_PARITY_EN -- when defined, the frame is start + 8 data + parity +
//                        stop. PARITY_ODD selects the parity sense (0 even,
//                        1 odd). When undefined, the frame is 8N1 and
//                        o_parity_err is tied low.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bit/s (BAUD*16 must not exceed CLK_FREQ)
//   PARITY_ODD  parity sense, used only with UART_RX_PARITY_EN
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   i_rx          in   raw serial input, idle high, asynchronous to clk
//   o_data        out  last good byte; changes only together with o_valid
//   o_valid       out  1-clk pulse: o_data holds a new byte
//   o_frame_err   out  1-clk pulse: stop bit was sampled low
//   o_parity_err  out  1-clk pulse: parity mismatch on an otherwise good frame
//   o_busy        out  high from a detected start edge until the FSM is IDLE
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);

    // Elaboration-time sanity checks on the parameters.
    if (BAUD * 16 > CLK_FREQ) begin : g_chk_baud
        $error("uart_rx_os16: BAUD*16 must not exceed CLK_FREQ");
    end
    if (PARITY_ODD > 1) begin : g_chk_parity
        $error("uart_rx_os16: PARITY_ODD must be 0 or 1");
    end

    localparam logic [31:0] ACC_INC  = 32'(BAUD * 16);
    localparam logic [31:0] ACC_WRAP = 32'(CLK_FREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser and edge detector. All of them reset to the idle level, so
    // leaving reset never looks like a start edge.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    state_t      state_q,    state_d;
    logic [31:0] acc_q,      acc_d;
    logic [3:0]  tick_idx_q, tick_idx_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic        s7_q,       s7_d;
    logic        s8_q,       s8_d;
    logic [7:0]  data_q,     data_d;
    logic        valid_q,    valid_d;
    logic        ferr_q,     ferr_d;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q,  par_bad_d;
    logic        perr_q,     perr_d;
`endif

    logic [31:0] acc_sum;
    logic        tick;
    logic        start_edge;
    logic        vote;
    logic        at_t9;
    logic        at_t15;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Fractional tick: acc_q always stays below CLK_FREQ, so the sum fits in
    // 32 bits for any legal parameter set.
    assign acc_sum    = acc_q + ACC_INC;
    assign tick       = (acc_sum >= ACC_WRAP);
    assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_s_q;

    // Evaluate the majority with the live synchronised sample. That value
    // is the tick-9 sample when used at the tick-9 decision point.
    assign vote   = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    assign at_t9  = tick && (tick_idx_q == 4'd9);
    assign at_t15 = tick && (tick_idx_q == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            tick_idx_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            s7_q       <= 1'b0;
            s8_q       <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tick_idx_q <= tick_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_sum;
        tick_idx_d = tick_idx_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        perr_d     = 1'b0;
`endif

        // The start edge restarts the tick phase, so tick index 0 is the
        // first tick after the edge and tick 15 ends each bit period.
        if (start_edge) begin
            acc_d      = '0;
            tick_idx_d = '0;
        end else if (tick) begin
            acc_d      = acc_sum - ACC_WRAP;
            tick_idx_d = tick_idx_q + 4'd1;
        end

        if (tick && (tick_idx_q == 4'd7)) begin
            s7_d = rx_s_q;
        end
        if (tick && (tick_idx_q == 4'd8)) begin
            s8_d = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end

            S_START: begin
                // A line that is high again at mid-bit was only a glitch.
                if (at_t9 && vote) begin
                    state_d = S_IDLE;
                end else if (at_t15) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (at_t9) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (at_t15) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at_t9) begin
                    par_bad_d = vote ^ (^shift_q) ^ 1'(PARITY_ODD);
                end
                if (at_t15) begin
                    state_d = S_STOP;
                end
            end
`endif

            S_STOP: begin
                // Decide at mid-stop-bit so a back-to-back start edge at the
                // end of the stop bit finds the FSM already in IDLE.
                if (at_t9) begin
                    if (!vote) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_BREAK: begin
                // Wait for the line to return high before re-arming, so a
                // held-low line cannot start a new frame.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
